// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//   Shares one single-port synchronous data RAM between the core write-back
//   stage and an external host/DMA port. The core has priority. A starvation
//   counter forces a host access after max_core_run consecutive contended
//   core grants. Read data returns one cycle after the read is granted, and
//   the matching rvalid flags which requester owned that read.
//
// Ports
//   clk, rst                       clock (posedge), synchronous active-high reset
//   core_rd/core_wr/core_addr/     core request from EX/WB register
//   core_wdata
//   core_stall                     core request not serviced this cycle
//   core_rvalid/core_rdata         core read return (1-cycle latency)
//   host_req/host_we/host_addr/    host request, held stable until host_gnt
//   host_wdata
//   host_gnt                       host access performed this cycle
//   host_rvalid/host_rdata         host read return (1-cycle latency)
//   ram_en/ram_we/ram_addr/        RAM command port
//   ram_wdata
//   ram_rdata                      RAM read data, one cycle after a read
//   err_rdwr                       sticky: core_rd and core_wr seen together
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
    parameter int addr_width   = 10,
    parameter int data_width   = 32,
    parameter int max_core_run = 4,
    parameter int cnt_width    = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [addr_width-1:0] core_addr,
    input  logic [data_width-1:0] core_wdata,
    output logic                  core_stall,
    output logic                  core_rvalid,
    output logic [data_width-1:0] core_rdata,

    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [addr_width-1:0] host_addr,
    input  logic [data_width-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [data_width-1:0] host_rdata,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_wdata,
    input  logic [data_width-1:0] ram_rdata,

    output logic                  err_rdwr
);

    localparam logic [cnt_width-1:0] MAX_RUN = cnt_width'(max_core_run);

    logic                 w_core_req;
    logic                 w_host_win;
    logic                 w_core_win;

    logic [cnt_width-1:0] r_starve_cnt;
    logic                 r_core_rvalid;
    logic                 r_host_rvalid;
    logic                 r_err_rdwr;

    // Grant: host only wins an idle cycle or once the core has had its run.
    assign w_core_req = core_rd | core_wr;
    assign w_host_win = host_req & (~w_core_req | (r_starve_cnt == MAX_RUN));
    assign w_core_win = w_core_req & ~w_host_win;

    assign core_stall = w_core_req & w_host_win;
    assign host_gnt   = w_host_win;

    // RAM command mux. With no winner the address/data simply follow the
    // core fields; they are ignored because ram_en is low.
    always_comb begin
        ram_en    = w_core_win | w_host_win;
        ram_we    = 1'b0;
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        if (w_host_win) begin
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end else if (w_core_win) begin
            // rd+wr together is serviced as a write
            ram_we    = core_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt  <= '0;
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_err_rdwr    <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_win & ~core_wr;
            r_host_rvalid <= w_host_win & ~host_we;
            if (core_rd & core_wr) begin
                r_err_rdwr <= 1'b1;
            end
            // Count only contended core wins; any host grant or idle host
            // restarts the run.
            if (w_host_win | ~host_req) begin
                r_starve_cnt <= '0;
            end else if (w_core_win && (r_starve_cnt != MAX_RUN)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign core_rvalid = r_core_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign core_rdata  = ram_rdata;
    assign host_rdata  = ram_rdata;
    assign err_rdwr    = r_err_rdwr;

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          err_rdwr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(
        .addr_width  (AW),
        .data_width  (DW),
        .max_core_run(4),
        .cnt_width   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .err_rdwr   (err_rdwr)
    );

    // Behavioural single-port synchronous RAM
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic          rst;
        logic          crd, cwr;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwdata;
        logic          hreq, hwe;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwdata;
        logic          e_stall, e_gnt, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_crv, e_hrv;
        logic [DW-1:0] e_rdata;
        logic          e_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic crd, input logic cwr,
                         input logic [AW-1:0] caddr, input logic [DW-1:0] cwdata,
                         input logic hreq, input logic hwe,
                         input logic [AW-1:0] haddr, input logic [DW-1:0] hwdata);
        @(negedge clk);
        rst = r; core_rd = crd; core_wr = cwr; core_addr = caddr; core_wdata = cwdata;
        host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwdata;
        #1;
    endtask

    // Core read 0x005 against host read 0x3FF, held for ncore core wins,
    // optionally followed by the forced host cycle.
    task automatic contend(input string tag, input int ncore, input bit host_end);
        for (int i = 0; i < ncore; i++) begin
            drive(1'b0, 1'b1, 1'b0, 10'h005, '0, 1'b1, 1'b0, 10'h3FF, '0);
            chk({tag, "_core_gnt"},   {31'b0, host_gnt},   32'd0);
            chk({tag, "_core_stall"}, {31'b0, core_stall}, 32'd0);
            chk({tag, "_core_addr"},  {22'b0, ram_addr},   32'h005);
            chk({tag, "_rv_excl"},    {31'b0, core_rvalid & host_rvalid}, 32'd0);
        end
        if (host_end) begin
            drive(1'b0, 1'b1, 1'b0, 10'h005, '0, 1'b1, 1'b0, 10'h3FF, '0);
            chk({tag, "_host_gnt"},   {31'b0, host_gnt},   32'd1);
            chk({tag, "_host_stall"}, {31'b0, core_stall}, 32'd1);
            chk({tag, "_host_addr"},  {22'b0, ram_addr},   32'h3FF);
            chk({tag, "_host_we"},    {31'b0, ram_we},     32'd0);
        end
    endtask

    initial begin
        //          rst crd cwr caddr   cwdata         hreq hwe haddr   hwdata
        //          stall gnt en we eaddr ewdata        crv hrv erdata        err
        vecs[0]  = '{0,0,0,10'h000,32'h0,        0,0,10'h000,32'h0,
                     0,0,0,0,10'h000,32'h0,        0,0,32'h0,        0};
        vecs[1]  = '{0,0,0,10'h000,32'h0,        1,1,10'h005,32'hDEADBEEF,
                     0,1,1,1,10'h005,32'hDEADBEEF, 0,0,32'h0,        0};
        vecs[2]  = '{0,0,0,10'h000,32'h0,        1,0,10'h005,32'h0,
                     0,1,1,0,10'h005,32'h0,        0,0,32'h0,        0};
        vecs[3]  = '{0,0,0,10'h000,32'h0,        0,0,10'h000,32'h0,
                     0,0,0,0,10'h000,32'h0,        0,1,32'hDEADBEEF, 0};
        vecs[4]  = '{0,0,1,10'h3FF,32'h12345678, 0,0,10'h000,32'h0,
                     0,0,1,1,10'h3FF,32'h12345678, 0,0,32'h0,        0};
        vecs[5]  = '{0,1,0,10'h3FF,32'h0,        0,0,10'h000,32'h0,
                     0,0,1,0,10'h3FF,32'h0,        0,0,32'h0,        0};
        vecs[6]  = '{0,0,0,10'h000,32'h0,        0,0,10'h000,32'h0,
                     0,0,0,0,10'h000,32'h0,        1,0,32'h12345678, 0};
        vecs[7]  = '{0,1,0,10'h005,32'h0,        0,0,10'h000,32'h0,
                     0,0,1,0,10'h005,32'h0,        0,0,32'h0,        0};
        vecs[8]  = '{0,0,0,10'h000,32'h0,        1,0,10'h3FF,32'h0,
                     0,1,1,0,10'h3FF,32'h0,        1,0,32'hDEADBEEF, 0};
        vecs[9]  = '{0,0,0,10'h000,32'h0,        0,0,10'h000,32'h0,
                     0,0,0,0,10'h000,32'h0,        0,1,32'h12345678, 0};
        vecs[10] = '{0,1,1,10'h010,32'hA5A5A5A5, 0,0,10'h000,32'h0,
                     0,0,1,1,10'h010,32'hA5A5A5A5, 0,0,32'h0,        0};
        vecs[11] = '{0,1,0,10'h010,32'h0,        0,0,10'h000,32'h0,
                     0,0,1,0,10'h010,32'h0,        0,0,32'h0,        1};
        vecs[12] = '{0,0,0,10'h000,32'h0,        0,0,10'h000,32'h0,
                     0,0,0,0,10'h000,32'h0,        1,0,32'hA5A5A5A5, 1};

        rst = 1'b1; core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(posedge clk);

        // Table: reset state, host-only, core-only, back-to-back, rd+wr
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].rst, vecs[v].crd, vecs[v].cwr, vecs[v].caddr, vecs[v].cwdata,
                  vecs[v].hreq, vecs[v].hwe, vecs[v].haddr, vecs[v].hwdata);
            chk($sformatf("v%0d_stall", v), {31'b0, core_stall}, {31'b0, vecs[v].e_stall});
            chk($sformatf("v%0d_gnt", v),   {31'b0, host_gnt},   {31'b0, vecs[v].e_gnt});
            chk($sformatf("v%0d_en", v),    {31'b0, ram_en},     {31'b0, vecs[v].e_en});
            chk($sformatf("v%0d_we", v),    {31'b0, ram_we},     {31'b0, vecs[v].e_we});
            if (vecs[v].e_en)
                chk($sformatf("v%0d_addr", v), {22'b0, ram_addr}, {22'b0, vecs[v].e_addr});
            if (vecs[v].e_we)
                chk($sformatf("v%0d_wdata", v), ram_wdata, vecs[v].e_wdata);
            chk($sformatf("v%0d_crv", v),   {31'b0, core_rvalid}, {31'b0, vecs[v].e_crv});
            chk($sformatf("v%0d_hrv", v),   {31'b0, host_rvalid}, {31'b0, vecs[v].e_hrv});
            if (vecs[v].e_crv)
                chk($sformatf("v%0d_crdata", v), core_rdata, vecs[v].e_rdata);
            if (vecs[v].e_hrv)
                chk($sformatf("v%0d_hrdata", v), host_rdata, vecs[v].e_rdata);
            chk($sformatf("v%0d_err", v),   {31'b0, err_rdwr}, {31'b0, vecs[v].e_err});
        end

        // T3: contention, forced host access every fifth cycle
        contend("t3a", 4, 1'b1);
        contend("t3b", 4, 1'b1);
        chk("t3_err_sticky", {31'b0, err_rdwr}, 32'd1);

        // T4: host drops request mid-run, counter restarts
        contend("t4a", 2, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, 10'h3FF, '0);
        chk("t4_idle_gnt",   {31'b0, host_gnt},   32'd0);
        chk("t4_idle_stall", {31'b0, core_stall}, 32'd0);
        contend("t4b", 4, 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        chk("t4_hrv_after", {31'b0, host_rvalid}, 32'd1);
        chk("t4_hrdata",    host_rdata,           32'h12345678);

        // Reset mid-run clears the starvation count; grants still follow
        // the equations while rst is high; a read in reset returns nothing.
        contend("t6pre", 3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 10'h005, '0, 1'b1, 1'b0, 10'h3FF, '0);
        chk("rst_core_wins", {31'b0, host_gnt}, 32'd0);
        chk("rst_en",        {31'b0, ram_en},   32'd1);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h005, '0);
        chk("rst_host_gnt",  {31'b0, host_gnt}, 32'd1);
        chk("rst_crv",       {31'b0, core_rvalid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        chk("rst_hrv",       {31'b0, host_rvalid}, 32'd0);
        chk("rst_err_clr",   {31'b0, err_rdwr},    32'd0);
        contend("t6post", 4, 1'b1);

        // T6: host read granted, reset next cycle
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h005, '0);
        chk("t6_gnt", {31'b0, host_gnt}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        chk("t6_hrv", {31'b0, host_rvalid}, 32'd0);
        chk("t6_crv", {31'b0, core_rvalid}, 32'd0);
        chk("t6_err", {31'b0, err_rdwr},    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
